ccd_capture_sequencer: RTL and testbench
========================================

// Module: ccd_capture_sequencer
// PURPOSE
//  Avalon-MM controlled sequencer for the CCD camera path: arms capture, counts N frames (or runs free),
//  stops capture, and steps sensor exposure via the I2C config block's adjust inputs. Sits between the
//  Nios/Avalon fabric and the capture/I2C-config conduit; raises an IRQ on completion/error.
// PARAMETERS
//  SYNC_STAGES     2           flops in frame-valid synchronizer (>=2)
//  TIMEOUT_CYCLES  50_000_000  iclk cycles with no fval edge in ARM/CAPTURE before forced stop
//  PULSE_WIDTH     4           iclk cycles oexposure_adj held high per step
//  PULSE_GAP       1_000_000   iclk cycles low between exposure steps (lets I2C write finish)
// PORTS
//  iclk             in   1   system clock (Avalon clock)
//  irst             in   1   reset; asynchronous assert, active-high
//  iaddress         in   3   Avalon word address
//  iread            in   1   Avalon read strobe
//  iwrite           in   1   Avalon write strobe
//  iwritedata       in   32  Avalon write data
//  oreaddata        out  32  Avalon read data, fixed 1-cycle read latency
//  ifval            in   1   camera frame-valid, asynchronous to iclk
//  ostart           out  1   1-cycle start pulse to capture block
//  oend             out  1   1-cycle end pulse to capture block
//  oexposure_dec_p  out  1   exposure direction level (1 = decrease), stable during a step sequence
//  oexposure_adj    out  1   exposure step pulse to I2C config
//  obusy            out  1   high when sequencer state != IDLE
//  oirq             out  1   level interrupt = irq_en & (done | timeout | err)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, all registers 0, frame counter 0, stepper idle.
//  Registers (word addr): 0 CTRL W: b0 go, b1 continuous, b2 abort, b3 irq_en (b3 retained, b0/b2 self-clear)
//   1 TARGET RW [15:0] frames to capture; 2 STATUS R: b0 done, b1 timeout, b2 err, b3 busy, b4 exp_busy,
//   [10:8] state; write-1-to-clear b0..b2; 3 FRAMES R [15:0] frames counted this run
//   4 EXPOSURE W: [7:0] step count, b8 direction; R returns remaining steps + dir. Unmapped: read 0, write ignored.
//  fval synchronized through SYNC_STAGES flops; rise/fall detected on synced value (1-cycle edge strobes).
//  FSM: IDLE -go-> ARM: ostart pulses on entry cycle; FRAMES cleared.
//   ARM -fval rise-> CAPTURE.  CAPTURE: each fval fall increments FRAMES (wraps 0xFFFF->0).
//   CAPTURE -(!continuous & FRAMES+1==TARGET on fall)-> STOP.  STOP: oend pulses 1 cycle -> DONE.
//   DONE: set done sticky -> IDLE next cycle.
//  go ignored unless IDLE. go with TARGET==0 and !continuous: stay IDLE, set err.
//  abort in ARM/CAPTURE -> STOP next cycle (done still set). Same write with go+abort: abort wins, go dropped.
//  Timeout: watchdog reloads on every synced fval edge and on ARM entry; expiry in ARM/CAPTURE -> STOP, set timeout.
//  FRAMES increment and TARGET match on same cycle as abort: count the frame, then STOP (single oend).
//  TARGET write while busy: takes effect immediately for the compare (no re-arm).
//  Exposure stepper: write to reg 4 when idle with count>0 loads count, latches dir to oexposure_dec_p;
//   emits count pulses, each PULSE_WIDTH high then PULSE_GAP low; first pulse starts next cycle.
//   Write while exp_busy or count==0: ignored. Runs independently of capture FSM.
//  Read data registered: oreaddata valid the cycle after iread; holds last value otherwise.
//  irst mid-run: immediate return to reset values; no oend emitted.
// STRUCTURE
//  Package ccd_seq_pkg: register address constants, CTRL/STATUS bit indices, FSM state encoding
//   (IDLE=0, ARM=1, CAPTURE=2, STOP=3, DONE=4).
//  Sub-module ccd_exposure_stepper: count/dir load, PULSE_WIDTH/PULSE_GAP timers, busy/remaining outputs.
// TESTING  (use small params: TIMEOUT_CYCLES=200, PULSE_WIDTH=4, PULSE_GAP=10)
//  TARGET=3, go -> one ostart, 3 fval frames, FRAMES=3, one oend after 3rd fall, done=1, oirq if irq_en.
//  continuous go, 5 frames, then abort -> FRAMES=5, single oend, done=1, obusy falls within 3 cycles.
//  go with no fval activity -> STOP after 200 cycles, timeout=1, oend once; W1C STATUS=0x2 clears it.
//  TARGET=0, !continuous, go -> stays IDLE, err=1, no ostart; go+abort same write -> no ostart.
//  EXPOSURE write 0x103 -> dec_p=1, 3 pulses of 4 high/10 low; 2nd write mid-sequence ignored.
//  irst asserted in CAPTURE -> all outputs 0 same cycle, no oend; next go runs normally.

Source files
------------

// File: rtl/ccd_capture_sequencer_pkg.sv
// Shared constants for the CCD capture sequencer: register map, control and
// status bit positions, and the sequencer / exposure-stepper state encodings.
package ccd_seq_pkg;

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_TARGET   = 3'd1;
    localparam logic [2:0] ADDR_STATUS   = 3'd2;
    localparam logic [2:0] ADDR_FRAMES   = 3'd3;
    localparam logic [2:0] ADDR_EXPOSURE = 3'd4;

    localparam int CTRL_GO     = 0;
    localparam int CTRL_CONT   = 1;
    localparam int CTRL_ABORT  = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int ST_DONE    = 0;
    localparam int ST_TIMEOUT = 1;
    localparam int ST_ERR     = 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_CAPTURE = 3'd2,
        S_STOP    = 3'd3,
        S_DONE    = 3'd4
    } seq_state_e;

    typedef enum logic [1:0] {
        EXP_IDLE = 2'd0,
        EXP_HIGH = 2'd1,
        EXP_LOW  = 2'd2
    } exp_phase_e;

endpackage

// File: rtl/ccd_capture_sequencer_if.sv
// Avalon-MM slave bus bundle between the Nios fabric and the capture sequencer.
interface ccd_capture_sequencer_if;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, read, write, writedata, input readdata);
    modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/ccd_exposure_stepper.sv
// Exposure stepper: emits a burst of adjust pulses (PULSE_WIDTH high, PULSE_GAP
// low) with a latched direction level, giving the I2C block time per write.
module ccd_exposure_stepper
    import ccd_seq_pkg::*;
#(
    parameter int PULSE_WIDTH = 4,
    parameter int PULSE_GAP   = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_count,
    input  logic       load_dir,
    output logic       adj,
    output logic       dec_p,
    output logic       busy,
    output logic [7:0] remaining
);

    localparam int TW = $clog2((PULSE_GAP > PULSE_WIDTH) ? PULSE_GAP : PULSE_WIDTH) + 1;

    exp_phase_e phase_r, phase_n;
    logic [TW-1:0] timer_r, timer_n;
    logic [7:0]    remaining_r, remaining_n;
    logic          dir_r, dir_n;
    logic          adj_r, busy_r;

    // Phase sequencing: load only from idle, then alternate high/low phases
    always_comb begin
        phase_n     = phase_r;
        timer_n     = timer_r;
        remaining_n = remaining_r;
        dir_n       = dir_r;
        case (phase_r)
            EXP_IDLE: begin
                if (load && (load_count != 8'd0)) begin
                    phase_n     = EXP_HIGH;
                    timer_n     = TW'(PULSE_WIDTH - 1);
                    remaining_n = load_count;
                    dir_n       = load_dir;
                end else begin
                    phase_n = EXP_IDLE;
                end
            end
            EXP_HIGH: begin
                if (timer_r == TW'(0)) begin
                    phase_n     = EXP_LOW;
                    timer_n     = TW'(PULSE_GAP - 1);
                    remaining_n = remaining_r - 8'd1;
                end else begin
                    timer_n = timer_r - TW'(1);
                end
            end
            EXP_LOW: begin
                if (timer_r == TW'(0)) begin
                    if (remaining_r == 8'd0) begin
                        phase_n = EXP_IDLE;
                    end else begin
                        phase_n = EXP_HIGH;
                        timer_n = TW'(PULSE_WIDTH - 1);
                    end
                end else begin
                    timer_n = timer_r - TW'(1);
                end
            end
            default: phase_n = EXP_IDLE;
        endcase
    end

    // Stepper state and registered pulse/busy outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r     <= EXP_IDLE;
            timer_r     <= '0;
            remaining_r <= 8'd0;
            dir_r       <= 1'b0;
            adj_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            phase_r     <= phase_n;
            timer_r     <= timer_n;
            remaining_r <= remaining_n;
            dir_r       <= dir_n;
            adj_r       <= (phase_n == EXP_HIGH);
            busy_r      <= (phase_n != EXP_IDLE);
        end
    end

    assign adj       = adj_r;
    assign dec_p     = dir_r;
    assign busy      = busy_r;
    assign remaining = remaining_r;

endmodule

// File: rtl/ccd_capture_sequencer.sv
// CCD capture sequencer: Avalon-MM register block that arms the capture path,
// counts frames from an asynchronous frame-valid, stops on target/abort/timeout
// and drives the exposure stepper.
module ccd_capture_sequencer
    import ccd_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int PULSE_WIDTH    = 4,
    parameter int PULSE_GAP      = 1_000_000
) (
    input  logic                    iclk,
    input  logic                    irst,
    ccd_capture_sequencer_if.slave  bus,
    input  logic                    ifval,
    output logic                    ostart,
    output logic                    oend,
    output logic                    oexposure_dec_p,
    output logic                    oexposure_adj,
    output logic                    obusy,
    output logic                    oirq
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

    seq_state_e state_r, state_n;
    logic [SYNC_STAGES-1:0] fval_sync_r;
    logic        fval_prev_r, fval_rise_s, fval_fall_s, fval_edge_s;
    logic        ctrl_wr_s, go_s, abort_s, status_wr_s, target_wr_s, exp_wr_s;
    logic        cont_r, cont_n, irq_en_r, irq_en_n;
    logic        done_r, done_n, timeout_r, timeout_n, err_r, err_n;
    logic [15:0] target_r, frames_r;
    logic [WD_W-1:0] wd_r;
    logic        running_s, timeout_s, frame_done_s, arm_entry_s, err_set_s;
    logic        ostart_r, oend_r, obusy_r, oirq_r;
    logic [31:0] readdata_r;
    logic        exp_busy_s;
    logic [7:0]  exp_remaining_s;
    logic        unused_wdata_s;

    assign ctrl_wr_s   = bus.write && (bus.address == ADDR_CTRL);
    assign target_wr_s = bus.write && (bus.address == ADDR_TARGET);
    assign status_wr_s = bus.write && (bus.address == ADDR_STATUS);
    assign exp_wr_s    = bus.write && (bus.address == ADDR_EXPOSURE);
    // abort takes precedence over go in the same write
    assign abort_s     = ctrl_wr_s && bus.writedata[CTRL_ABORT];
    assign go_s        = ctrl_wr_s && bus.writedata[CTRL_GO] && !bus.writedata[CTRL_ABORT];
    assign unused_wdata_s = ^bus.writedata[31:16];

    assign fval_rise_s  = fval_sync_r[SYNC_STAGES-1] & ~fval_prev_r;
    assign fval_fall_s  = ~fval_sync_r[SYNC_STAGES-1] & fval_prev_r;
    assign fval_edge_s  = fval_rise_s | fval_fall_s;
    assign running_s    = (state_r == S_ARM) || (state_r == S_CAPTURE);
    assign timeout_s    = running_s && (wd_r == WD_W'(0)) && !fval_edge_s;
    assign frame_done_s = !cont_r && ((frames_r + 16'd1) == target_r);
    assign arm_entry_s  = (state_r == S_IDLE) && (state_n == S_ARM);

    // Frame-valid synchronizer plus one-cycle history for edge detection
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            fval_sync_r <= '0;
            fval_prev_r <= 1'b0;
        end else begin
            fval_sync_r <= {fval_sync_r[SYNC_STAGES-2:0], ifval};
            fval_prev_r <= fval_sync_r[SYNC_STAGES-1];
        end
    end

    // Sequencer next-state: go/err in idle, stop on target, abort or watchdog
    always_comb begin
        state_n   = state_r;
        err_set_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (go_s && (target_r == 16'd0) && !bus.writedata[CTRL_CONT]) begin
                    err_set_s = 1'b1;
                end else if (go_s) begin
                    state_n = S_ARM;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_ARM: begin
                if (abort_s || timeout_s) begin
                    state_n = S_STOP;
                end else if (fval_rise_s) begin
                    state_n = S_CAPTURE;
                end else begin
                    state_n = S_ARM;
                end
            end
            S_CAPTURE: begin
                if (abort_s || timeout_s || (fval_fall_s && frame_done_s)) begin
                    state_n = S_STOP;
                end else begin
                    state_n = S_CAPTURE;
                end
            end
            S_STOP:  state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Next values of retained control bits and sticky status (set beats W1C)
    always_comb begin
        cont_n    = ctrl_wr_s ? bus.writedata[CTRL_CONT]   : cont_r;
        irq_en_n  = ctrl_wr_s ? bus.writedata[CTRL_IRQ_EN] : irq_en_r;
        done_n    = (state_r == S_STOP) | (done_r & ~(status_wr_s & bus.writedata[ST_DONE]));
        timeout_n = timeout_s | (timeout_r & ~(status_wr_s & bus.writedata[ST_TIMEOUT]));
        err_n     = err_set_s | (err_r & ~(status_wr_s & bus.writedata[ST_ERR]));
    end

    // State, registers, watchdog and registered strobes/levels
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_r   <= S_IDLE;
            cont_r    <= 1'b0;
            irq_en_r  <= 1'b0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            err_r     <= 1'b0;
            target_r  <= 16'd0;
            frames_r  <= 16'd0;
            wd_r      <= '0;
            ostart_r  <= 1'b0;
            oend_r    <= 1'b0;
            obusy_r   <= 1'b0;
            oirq_r    <= 1'b0;
        end else begin
            state_r   <= state_n;
            cont_r    <= cont_n;
            irq_en_r  <= irq_en_n;
            done_r    <= done_n;
            timeout_r <= timeout_n;
            err_r     <= err_n;
            if (target_wr_s) begin
                target_r <= bus.writedata[15:0];
            end
            if (arm_entry_s) begin
                frames_r <= 16'd0;
            end else if ((state_r == S_CAPTURE) && fval_fall_s) begin
                frames_r <= frames_r + 16'd1;
            end
            if (arm_entry_s || fval_edge_s) begin
                wd_r <= WD_W'(TIMEOUT_CYCLES - 1);
            end else if (running_s && (wd_r != WD_W'(0))) begin
                wd_r <= wd_r - WD_W'(1);
            end
            ostart_r <= arm_entry_s;
            oend_r   <= (state_n == S_STOP) && (state_r != S_STOP);
            obusy_r  <= (state_n != S_IDLE);
            oirq_r   <= irq_en_n & (done_n | timeout_n | err_n);
        end
    end

    // Registered read data, one-cycle latency, held between reads
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            readdata_r <= 32'd0;
        end else if (bus.read) begin
            case (bus.address)
                ADDR_TARGET:   readdata_r <= {16'd0, target_r};
                ADDR_STATUS:   readdata_r <= {21'd0, state_r, 3'd0, exp_busy_s, obusy_r,
                                              err_r, timeout_r, done_r};
                ADDR_FRAMES:   readdata_r <= {16'd0, frames_r};
                ADDR_EXPOSURE: readdata_r <= {23'd0, oexposure_dec_p, exp_remaining_s};
                default:       readdata_r <= 32'd0;
            endcase
        end
    end

    ccd_exposure_stepper #(
        .PULSE_WIDTH (PULSE_WIDTH),
        .PULSE_GAP   (PULSE_GAP)
    ) u_stepper (
        .clk        (iclk),
        .rst        (irst),
        .load       (exp_wr_s),
        .load_count (bus.writedata[7:0]),
        .load_dir   (bus.writedata[8]),
        .adj        (oexposure_adj),
        .dec_p      (oexposure_dec_p),
        .busy       (exp_busy_s),
        .remaining  (exp_remaining_s)
    );

    assign bus.readdata = readdata_r;
    assign ostart       = ostart_r;
    assign oend         = oend_r;
    assign obusy        = obusy_r;
    assign oirq         = oirq_r;

endmodule

// File: tb/tb_ccd_capture_sequencer.sv
// Self-checking bench for ccd_capture_sequencer with small timing parameters.
module tb_ccd_capture_sequencer;
    import ccd_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fval = 1'b0;
    logic ostart, oend, dec_p, adj, obusy, oirq;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    int start_cnt = 0;
    int end_cnt = 0;
    int hi_n = 0;
    int lo_n = 0;
    int run = 0;
    int hi_len[16] = '{default: 0};
    int lo_len[16] = '{default: 0};
    logic adj_prev = 1'b0;

    ccd_capture_sequencer_if bus ();

    ccd_capture_sequencer #(
        .SYNC_STAGES(2), .TIMEOUT_CYCLES(200), .PULSE_WIDTH(4), .PULSE_GAP(10)
    ) dut (
        .iclk(clk), .irst(rst), .bus(bus), .ifval(fval),
        .ostart(ostart), .oend(oend), .oexposure_dec_p(dec_p),
        .oexposure_adj(adj), .obusy(obusy), .oirq(oirq)
    );

    always #5 clk = ~clk;

    // Output monitor: pulse counts and exposure high/low run lengths
    always @(negedge clk) begin
        if (ostart === 1'b1) start_cnt <= start_cnt + 1;
        if (oend === 1'b1) end_cnt <= end_cnt + 1;
        if (adj !== adj_prev) begin
            if (adj_prev) begin hi_len[hi_n % 16] <= run; hi_n <= hi_n + 1; end
            else begin lo_len[lo_n % 16] <= run; lo_n <= lo_n + 1; end
            run <= 1;
        end else begin
            run <= run + 1;
        end
        adj_prev <= adj;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.address = a; bus.writedata = d; bus.write = 1'b1;
        @(posedge clk); #1;
        bus.write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        bus.address = a; bus.read = 1'b1;
        @(posedge clk); #1;
        bus.read = 1'b0;
        d = bus.readdata;
    endtask

    task automatic drive_frame(input int hi, input int lo);
        @(posedge clk); #3 fval = 1'b1;
        repeat (hi) @(posedge clk);
        #3 fval = 1'b0;
        repeat (lo) @(posedge clk);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (obusy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    endtask

    task automatic test_reset();
        logic [31:0] rd, ex;
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({ostart, oend, dec_p, adj, obusy, oirq} !== 6'b0 || bus.readdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b rd %h, want 000000 rd 0",
                     {ostart, oend, dec_p, adj, obusy, oirq}, bus.readdata);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        for (int a = 1; a <= 4; a++) begin
            exp_q.push_back(32'd0);
            bus_read(3'(a), rd);
            ex = exp_q.pop_front();
            checks++;
            if (rd !== ex) begin errors++; $display("FAIL reset_reg%0d: got %h want %h", a, rd, ex); end
        end
    endtask

    task automatic test_capture_target();
        int s0, e0, n;
        logic [31:0] rd, ex;
        s0 = start_cnt; e0 = end_cnt;
        bus_write(ADDR_TARGET, 32'd3);
        bus_write(ADDR_CTRL, 32'h9);
        repeat (2) drive_frame(5, 5);
        checks++;
        if (end_cnt != e0 || obusy !== 1'b1) begin
            errors++; $display("FAIL target_early: oend %0d busy %b, want 0 1", end_cnt - e0, obusy);
        end
        drive_frame(5, 5);
        wait_idle(n);
        checks++;
        if (start_cnt - s0 != 1) begin errors++; $display("FAIL target_ostart: got %0d want 1", start_cnt - s0); end
        checks++;
        if (end_cnt - e0 != 1) begin errors++; $display("FAIL target_oend: got %0d want 1", end_cnt - e0); end
        checks++;
        if (oirq !== 1'b1) begin errors++; $display("FAIL target_irq: got %b want 1", oirq); end
        exp_q.push_back(32'd3);
        exp_q.push_back(32'h1);
        bus_read(ADDR_FRAMES, rd); ex = exp_q.pop_front();
        checks++;
        if (rd !== ex) begin errors++; $display("FAIL target_frames: got %h want %h", rd, ex); end
        bus_read(ADDR_STATUS, rd); ex = exp_q.pop_front();
        checks++;
        if (rd !== ex) begin errors++; $display("FAIL target_status: got %h want %h", rd, ex); end
        bus_write(ADDR_STATUS, 32'h1);
        @(negedge clk);
        checks++;
        if (oirq !== 1'b0) begin errors++; $display("FAIL target_irq_clear: got %b want 0", oirq); end
    endtask

    task automatic test_continuous_abort();
        int s0, e0, n;
        logic [31:0] rd, ex;
        s0 = start_cnt; e0 = end_cnt;
        bus_write(ADDR_CTRL, 32'h3);
        repeat (5) drive_frame(4, 6);
        exp_q.push_back(32'd5);
        exp_q.push_back(32'h208);
        bus_read(ADDR_FRAMES, rd); ex = exp_q.pop_front();
        checks++;
        if (rd !== ex) begin errors++; $display("FAIL cont_frames_run: got %h want %h", rd, ex); end
        bus_read(ADDR_STATUS, rd); ex = exp_q.pop_front();
        checks++;
        if (rd !== ex) begin errors++; $display("FAIL cont_status_run: got %h want %h", rd, ex); end
        bus_write(ADDR_CTRL, 32'h6);
        wait_idle(n);
        checks++;
        if (n > 3) begin errors++; $display("FAIL abort_latency: got %0d cycles want <=3", n); end
        checks++;
        if (start_cnt - s0 != 1 || end_cnt - e0 != 1) begin
            errors++; $display("FAIL abort_pulses: start %0d end %0d want 1 1", start_cnt - s0, end_cnt - e0);
        end
        exp_q.push_back(32'd5);
        exp_q.push_back(32'h1);
        bus_read(ADDR_FRAMES, rd); ex = exp_q.pop_front();
        checks++;
        if (rd !== ex) begin errors++; $display("FAIL abort_frames: got %h want %h", rd, ex); end
        bus_read(ADDR_STATUS, rd); ex = exp_q.pop_front();
        checks++;
        if (rd !== ex || oirq !== 1'b0) begin
            errors++; $display("FAIL abort_status: got %h irq %b want %h irq 0", rd, oirq, ex);
        end
        bus_write(ADDR_STATUS, 32'h1);
    endtask

    task automatic test_timeout();
        int e0, n;
        logic [31:0] rd, ex;
        e0 = end_cnt;
        bus_write(ADDR_CTRL, 32'h1);
        n = 0;
        while (end_cnt == e0 && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (n < 195 || n > 205) begin errors++; $display("FAIL timeout_cycles: got %0d want about 200", n); end
        repeat (5) @(negedge clk);
        checks++;
        if (end_cnt - e0 != 1) begin errors++; $display("FAIL timeout_oend: got %0d want 1", end_cnt - e0); end
        exp_q.push_back(32'h3);
        exp_q.push_back(32'h1);
        bus_read(ADDR_STATUS, rd); ex = exp_q.pop_front();
        checks++;
        if (rd !== ex) begin errors++; $display("FAIL timeout_status: got %h want %h", rd, ex); end
        bus_write(ADDR_STATUS, 32'h2);
        bus_read(ADDR_STATUS, rd); ex = exp_q.pop_front();
        checks++;
        if (rd !== ex) begin errors++; $display("FAIL timeout_w1c: got %h want %h", rd, ex); end
        bus_write(ADDR_STATUS, 32'h1);
    endtask

    task automatic test_go_errors();
        int s0;
        logic [31:0] rd, ex;
        s0 = start_cnt;
        bus_write(ADDR_TARGET, 32'd0);
        bus_write(ADDR_CTRL, 32'h1);
        repeat (3) @(negedge clk);
        checks++;
        if (start_cnt != s0 || obusy !== 1'b0) begin
            errors++; $display("FAIL err_idle: start %0d busy %b want 0 0", start_cnt - s0, obusy);
        end
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        bus_read(ADDR_STATUS, rd); ex = exp_q.pop_front();
        checks++;
        if (rd !== ex) begin errors++; $display("FAIL err_status: got %h want %h", rd, ex); end
        bus_write(ADDR_STATUS, 32'h4);
        bus_read(ADDR_STATUS, rd); ex = exp_q.pop_front();
        checks++;
        if (rd !== ex) begin errors++; $display("FAIL err_w1c: got %h want %h", rd, ex); end
        bus_write(ADDR_TARGET, 32'd3);
        bus_write(ADDR_CTRL, 32'h5);
        repeat (3) @(negedge clk);
        checks++;
        if (start_cnt != s0 || obusy !== 1'b0) begin
            errors++; $display("FAIL go_abort: start %0d busy %b want 0 0", start_cnt - s0, obusy);
        end
        bus_read(ADDR_STATUS, rd); ex = exp_q.pop_front();
        checks++;
        if (rd !== ex) begin errors++; $display("FAIL go_abort_status: got %h want %h", rd, ex); end
    endtask

    task automatic test_exposure();
        int h0, l0;
        logic [31:0] rd, ex;
        h0 = hi_n; l0 = lo_n;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'd4);
        for (int i = 0; i < 2; i++) exp_q.push_back(32'd10);
        bus_write(ADDR_EXPOSURE, 32'h103);
        @(negedge clk);
        checks++;
        if (adj !== 1'b1 || dec_p !== 1'b1) begin
            errors++; $display("FAIL exp_start: adj %b dec %b want 1 1", adj, dec_p);
        end
        bus_read(ADDR_EXPOSURE, rd);
        checks++;
        if (rd !== 32'h103) begin errors++; $display("FAIL exp_remaining: got %h want 103", rd); end
        bus_write(ADDR_EXPOSURE, 32'h005);
        bus_read(ADDR_STATUS, rd);
        checks++;
        if (rd !== 32'h10) begin errors++; $display("FAIL exp_busy: got %h want 10", rd); end
        repeat (60) @(negedge clk);
        checks++;
        if (hi_n - h0 != 3 || dec_p !== 1'b1) begin
            errors++; $display("FAIL exp_count: got %0d pulses dec %b want 3 1", hi_n - h0, dec_p);
        end
        for (int i = 0; i < 3; i++) begin
            ex = exp_q.pop_front();
            checks++;
            if (32'(hi_len[(h0 + i) % 16]) !== ex) begin
                errors++; $display("FAIL exp_high%0d: got %0d want %0d", i, hi_len[(h0 + i) % 16], ex);
            end
        end
        for (int i = 1; i < 3; i++) begin
            ex = exp_q.pop_front();
            checks++;
            if (32'(lo_len[(l0 + i) % 16]) !== ex) begin
                errors++; $display("FAIL exp_gap%0d: got %0d want %0d", i, lo_len[(l0 + i) % 16], ex);
            end
        end
        bus_read(ADDR_EXPOSURE, rd);
        checks++;
        if (rd !== 32'h100) begin errors++; $display("FAIL exp_final: got %h want 100", rd); end
    endtask

    task automatic test_reset_mid_run();
        int s0, e0, n;
        logic [31:0] rd, ex;
        bus_write(ADDR_CTRL, 32'h1);
        @(posedge clk); #3 fval = 1'b1;
        repeat (6) @(posedge clk);
        bus_read(ADDR_STATUS, rd);
        checks++;
        if (rd !== 32'h208) begin errors++; $display("FAIL rst_pre_state: got %h want 208", rd); end
        e0 = end_cnt;
        @(posedge clk); #2 rst = 1'b1;
        #1;
        checks++;
        if ({ostart, oend, dec_p, adj, obusy, oirq} !== 6'b0) begin
            errors++; $display("FAIL rst_outputs: got %b want 000000", {ostart, oend, dec_p, adj, obusy, oirq});
        end
        fval = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (end_cnt != e0) begin errors++; $display("FAIL rst_no_oend: got %0d want 0", end_cnt - e0); end
        exp_q.push_back(32'd0);
        bus_read(ADDR_TARGET, rd); ex = exp_q.pop_front();
        checks++;
        if (rd !== ex) begin errors++; $display("FAIL rst_target: got %h want %h", rd, ex); end
        s0 = start_cnt; e0 = end_cnt;
        bus_write(ADDR_TARGET, 32'd2);
        bus_write(ADDR_CTRL, 32'h1);
        repeat (2) drive_frame(5, 5);
        wait_idle(n);
        checks++;
        if (start_cnt - s0 != 1 || end_cnt - e0 != 1) begin
            errors++; $display("FAIL rerun_pulses: start %0d end %0d want 1 1", start_cnt - s0, end_cnt - e0);
        end
        exp_q.push_back(32'd2);
        bus_read(ADDR_FRAMES, rd); ex = exp_q.pop_front();
        checks++;
        if (rd !== ex) begin errors++; $display("FAIL rerun_frames: got %h want %h", rd, ex); end
    endtask

    initial begin
        bus.address = 3'd0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = 32'd0;
        test_reset();
        test_capture_target();
        test_continuous_abort();
        test_timeout();
        test_go_errors();
        test_exposure();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
